// File: rtl/tap_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tap_counter : prescaled up/down/one-shot/bounce counter with LED tap window
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tap_counter #(
  parameter int WIDTH   = 30,
  parameter int LED_W   = 8,
  parameter int PRESC_W = 16,
  parameter int TAP_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   limit,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic [TAP_W-1:0]   tap_sel,
  output logic [WIDTH-1:0]   cnt_out,
  output logic [LED_W-1:0]   leds,
  output logic               tc,
  output logic               done,
  output logic               dir
);

  typedef enum logic [1:0] {
    UP_WRAP   = 2'b00,
    DOWN_WRAP = 2'b01,
    ONESHOT   = 2'b10,
    BOUNCE    = 2'b11
  } mode_e;

  localparam int                 TAP_MAX   = WIDTH - LED_W;
  localparam logic [WIDTH-1:0]   CNT_ONE   = WIDTH'(1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  mode_e              mode_m;
  logic [PRESC_W-1:0] presc_q;
  logic               tick;
  logic [WIDTH-1:0]   cnt_nxt;
  logic               done_nxt;
  logic               dir_nxt;
  logic               tc_nxt;
  logic [31:0]        tap_ext;
  logic [31:0]        tap_eff;
  logic [LED_W-1:0]   led_win;

  assign mode_m = mode_e'(mode);

  // >= rather than == so that shrinking presc_div mid-count ticks at once.
  assign tick = en && (presc_q >= presc_div);

  assign tap_ext = 32'(tap_sel);
  assign tap_eff = (tap_ext > 32'(TAP_MAX)) ? 32'(TAP_MAX) : tap_ext;
  assign led_win = LED_W'(cnt_out >> tap_eff);

  always_comb begin
    cnt_nxt  = cnt_out;
    done_nxt = done;
    dir_nxt  = (mode_m == BOUNCE) ? dir : 1'b0;
    tc_nxt   = 1'b0;
    if (tick) begin
      case (mode_m)
        UP_WRAP: begin
          if (cnt_out >= limit) begin
            cnt_nxt = '0;
            tc_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_out + CNT_ONE;
          end
        end
        DOWN_WRAP: begin
          if (cnt_out == '0) begin
            cnt_nxt = limit;
            tc_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_out - CNT_ONE;
          end
        end
        ONESHOT: begin
          if (!done) begin
            if (cnt_out >= limit) begin
              done_nxt = 1'b1;
              tc_nxt   = 1'b1;
            end else begin
              cnt_nxt = cnt_out + CNT_ONE;
            end
          end
        end
        BOUNCE: begin
          if (!dir && (cnt_out >= limit)) begin
            dir_nxt = 1'b1;
            cnt_nxt = (limit == '0) ? '0 : cnt_out - CNT_ONE;
            tc_nxt  = 1'b1;
          end else if (dir && (cnt_out == '0)) begin
            dir_nxt = 1'b0;
            cnt_nxt = (limit == '0) ? '0 : cnt_out + CNT_ONE;
            tc_nxt  = 1'b1;
          end else begin
            cnt_nxt = dir ? cnt_out - CNT_ONE : cnt_out + CNT_ONE;
          end
        end
        default: cnt_nxt = cnt_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_out <= '0;
      presc_q <= '0;
      leds    <= '0;
      tc      <= 1'b0;
      done    <= 1'b0;
      dir     <= 1'b0;
    end else begin
      leds <= led_win;
      if (load) begin
        cnt_out <= load_val;
        presc_q <= '0;
        done    <= 1'b0;
        dir     <= 1'b0;
        tc      <= 1'b0;
      end else begin
        if (en) begin
          presc_q <= tick ? '0 : presc_q + PRESC_ONE;
        end
        cnt_out <= cnt_nxt;
        done    <= done_nxt;
        dir     <= dir_nxt;
        tc      <= tc_nxt;
      end
    end
  end

endmodule
`default_nettype wire
